// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Four-digit multiplexed 7-segment driver. A 14-bit binary score is latched
//   on load (saturated to 9999), converted to BCD with a sequential
//   shift-add-3 engine (one bit per cycle), then committed to the display
//   digit registers in a single edge. A free-running prescaler steps the
//   digit slot select so the anode decoder scans the four digits.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   load         request to display value_in (pulse or level)
//   value_in     14-bit unsigned value
//   blank_lz     1 = blank leading zeros (ones digit never blanks)
//   busy         conversion in progress; load ignored while high
//   counter_out  digit slot select, 0 = ones digit
//   seg          active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point, always off
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [13:0] value_in,
  input  logic        blank_lz,
  output logic        busy,
  output logic [1:0]  counter_out,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            PW   = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_slot;
  logic [13:0]     r_bin;
  logic [15:0]     r_bcd;
  logic [3:0]      r_bitcnt;
  logic [3:0][3:0] r_dig;

  logic [13:0]     w_sat;
  logic [15:0]     w_bcd_adj;
  logic [15:0]     w_bcd_shift;
  logic [3:0]      w_digit;
  logic            w_blank;

  // Scan prescaler and slot counter; independent of the converter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_slot  <= 2'd0;
    end else if (r_presc == PMAX) begin
      r_presc <= '0;
      r_slot  <= r_slot + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign counter_out = r_slot;

  // Converter FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (load) w_state_nxt = S_CONVERT;
      S_CONVERT: if (r_bitcnt == 4'd13) w_state_nxt = S_COMMIT;
      S_COMMIT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign w_sat = (value_in > 14'd9999) ? 14'd9999 : value_in;

  // Double dabble step: add 3 to any nibble >= 5, then shift in the next MSB.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  assign w_bcd_shift = {w_bcd_adj[14:0], r_bin[13]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_bitcnt <= '0;
      r_dig    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (load) begin
          r_bin    <= w_sat;
          r_bcd    <= '0;
          r_bitcnt <= '0;
        end
        S_CONVERT: begin
          r_bcd    <= w_bcd_shift;
          r_bin    <= {r_bin[12:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        S_COMMIT: r_dig <= r_bcd;  // all four digits change in one edge
        default: ;
      endcase
    end
  end

  // Segment output: selected digit, blanked if it and all higher digits are 0.
  assign w_digit = r_dig[r_slot];

  always_comb begin
    w_blank = 1'b0;
    case (r_slot)
      2'd1:    w_blank = (r_dig[3] == 4'd0) && (r_dig[2] == 4'd0) && (r_dig[1] == 4'd0);
      2'd2:    w_blank = (r_dig[3] == 4'd0) && (r_dig[2] == 4'd0);
      2'd3:    w_blank = (r_dig[3] == 4'd0);
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank && blank_lz;
  end

  always_comb begin
    seg = 7'b1111111;
    if (!w_blank) begin
      case (w_digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign dp = 1'b1;

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  request to display value_in; single-cycle pulse or level.
REQ-005 SHALL have port value_in  input  14  unsigned binary value to display (score).
REQ-006 SHALL have port blank_lz  input  1  1 = blank leading zeros.
REQ-007 SHALL have port busy  output  1  1 = conversion in progress, load ignored.
REQ-008 SHALL have port counter_out  output  2  digit slot select, feeds the anode decoder (0 = rightmost/ones digit).
REQ-009 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port dp  output  1  active-low decimal point.

Function
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the cycle where it equals REFRESH_DIV-1 is the refresh tick.
REQ-012 counter_out SHALL increment by 1 on the edge following each refresh tick and wrap 3->0; it SHALL be unaffected by load/busy.
REQ-013 The block SHALL hold four committed BCD digit registers d0 (ones) .. d3 (thousands).
REQ-014 Converter FSM states SHALL be IDLE, CONVERT, COMMIT.
REQ-015 IDLE: on a rising edge with load=1, the block SHALL latch min(value_in, 9999) and enter CONVERT; busy=1 from the next cycle.
REQ-016 CONVERT SHALL perform sequential shift-add-3 (double dabble) conversion, one bit per cycle, for exactly 14 cycles, then go to COMMIT.
REQ-017 COMMIT SHALL write all four digits d0..d3 in the same edge (atomic update, no partially updated value visible) and return to IDLE.
REQ-018 busy SHALL be 1 for exactly 15 cycles per accepted load (14 CONVERT + 1 COMMIT); the new digits SHALL be visible on seg in the first cycle busy=0.
REQ-019 load while busy=1 SHALL be ignored (not queued); a load held high SHALL be re-accepted in the first IDLE cycle.
REQ-020 value_in > 9999 SHALL saturate to 9999.
REQ-021 seg SHALL be a combinational function of counter_out, committed digits and blank_lz (same-cycle as counter_out).
REQ-022 Digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-023 With blank_lz=1, slot k (k=1..3) SHALL be blank when dk and all higher digits are 0; slot 0 SHALL never blank.
REQ-024 With blank_lz=0, all four digits SHALL always be shown.
REQ-025 dp SHALL be constant 1 (off).

Reset
REQ-026 reset=1 SHALL take priority over load and all counting, in any state.
REQ-027 On reset: prescaler=0, counter_out=0, d0..d3=0, FSM=IDLE, busy=0; seg=1000000 in the cycle after reset.
REQ-028 reset asserted mid-CONVERT SHALL abort the conversion; no commit SHALL occur and the digits SHALL read 0.

Verification
REQ-029 Reset, REFRESH_DIV=4 -> counter_out goes 0,1,2,3,0 changing every 4 cycles; seg=1000000 in slot 0.
REQ-030 load=1 one cycle, value_in=1234 -> busy high 15 cycles; afterwards slots 0..3 show 4,3,2,1 (0011001,0110000,0100100,1111001).
REQ-031 value_in=12000 -> display reads 9999 (all slots 0010000).
REQ-032 Load 1234, then load 5678 at busy cycle 5 -> second ignored; display 1234.
REQ-033 value_in=7, blank_lz=1 -> slot 0=1111000, slots 1..3=1111111; blank_lz=0 -> slots 1..3=1000000.
REQ-034 Load 9999, reset at CONVERT cycle 8 -> busy=0 next cycle, all digits 0, no later commit.
